// File: rtl/trading_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trading_pkg
//  Description : Shared constants and the loader state type for the
//                host-side packet path (host_word_loader -> DataManager).
//  Revision    : 1.0  initial release
// ============================================================================
package trading_pkg;

    // Number of book-side modules fed by one packet.
    localparam int BSMODS           = 4;
    // Width of one packet record as read by DataManager.
    localparam int DATASIZE         = 192;
    // 32-bit words that make up one record.
    localparam int WORDS_PER_RECORD = DATASIZE / 32;

    // Loader FSM encodings; plain constants keep older code that compares
    // against raw 3-bit values working.
    localparam logic [2:0] ST_FILL     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_DONE     = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_IDLEWAIT = 3'd4;

    typedef enum logic [2:0] {
        FILL     = ST_FILL,
        WRITE    = ST_WRITE,
        DONE     = ST_DONE,
        DRAIN    = ST_DRAIN,
        IDLEWAIT = ST_IDLEWAIT
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/host_word_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : host_word_loader_if
//  Description : Host byte stream, reader status and memory port B write
//                signals of the host word loader, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface host_word_loader_if;

    // Host byte stream
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_ready;

    // Reader status
    logic        OutOfData;

    // Shared memory port B and batch status
    logic [31:0] memAddrB;
    logic [31:0] memDataB;
    logic        memWeB;
    logic        DONE_WRITING;
    logic        busy;

    // Host / environment side
    modport master (
        output rx_data, rx_valid, rx_sof, OutOfData,
        input  rx_ready, memAddrB, memDataB, memWeB, DONE_WRITING, busy
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid, rx_sof, OutOfData,
        output rx_ready, memAddrB, memDataB, memWeB, DONE_WRITING, busy
    );

endinterface
`default_nettype wire

// File: rtl/host_word_loader_varcount.sv
`default_nettype none
// ============================================================================
//  Module      : VarCount
//  Description : Width-parameterised up-counter with clear and increment.
//                When both are asserted the count restarts from zero and is
//                then incremented, so a clear can coincide with a new event.
//  Revision    : 1.0  initial release
// ============================================================================
module VarCount #(
    parameter int WIDTH = 2
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             inc,
    input  wire logic             clear,
    output logic [WIDTH-1:0]      count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_base;

    // Starting point of the update: zero on clear, otherwise the held count.
    always_comb begin
        w_base = clear ? '0 : r_count;
    end

    // Counter register; wraps naturally at 2**WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || inc) begin
            r_count <= w_base + WIDTH'(inc);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/host_word_loader.sv
`default_nettype none
// ============================================================================
//  Module      : host_word_loader
//  Description : Packs a host byte stream little-endian into 32-bit words and
//                writes one batch of NUM_RECORDS*WORDS_PER_RECORD words to
//                shared memory port B from word address 0, then pulses
//                DONE_WRITING and waits for the reader to consume the batch.
//                Bytes are only taken while the reader reports OutOfData.
//  Revision    : 1.0  initial release
// ============================================================================
module host_word_loader #(
    parameter int WORDS_PER_RECORD = trading_pkg::WORDS_PER_RECORD,
    parameter int NUM_RECORDS      = 1,
    parameter int AW               = 30
) (
    input  wire logic          clock,
    input  wire logic          reset,
    host_word_loader_if.slave  bus
);

    import trading_pkg::*;

    localparam int            TOTAL       = NUM_RECORDS * WORDS_PER_RECORD;
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(TOTAL - 1);

    // Registered state
    logic [2:0]    r_state;
    logic [31:0]   r_word;
    logic          r_busy;

    // Counter values (held inside VarCount instances)
    logic [1:0]    w_byte_cnt;
    logic [AW-1:0] w_word_addr;

    // Combinational control
    logic [2:0]    w_state_nxt;
    logic          w_ready;
    logic          w_accept;
    logic          w_sof_accept;
    logic [1:0]    w_lane;
    logic          w_word_last;
    logic          w_byte_inc;
    logic          w_byte_clr;
    logic          w_addr_inc;
    logic          w_addr_clr;

    // Byte position inside the word being assembled.
    VarCount #(
        .WIDTH (2)
    ) u_byte_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_byte_inc),
        .clear (w_byte_clr),
        .count (w_byte_cnt)
    );

    // Word address of the next memory write.
    VarCount #(
        .WIDTH (AW)
    ) u_word_addr (
        .clock (clock),
        .reset (reset),
        .inc   (w_addr_inc),
        .clear (w_addr_clr),
        .count (w_word_addr)
    );

    // Handshake, counter control, next-state decode and port-B outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = (r_state == ST_FILL) && bus.OutOfData;
        w_accept     = bus.rx_valid && w_ready;
        w_sof_accept = w_accept && bus.rx_sof;
        // A start-of-batch byte always lands in lane 0, whatever was pending.
        w_lane       = w_sof_accept ? 2'd0 : w_byte_cnt;
        w_word_last  = (w_word_addr == C_LAST_ADDR);

        w_byte_inc   = w_accept;
        w_byte_clr   = w_sof_accept;
        w_addr_inc   = 1'b0;
        w_addr_clr   = w_sof_accept;

        unique case (r_state)
            ST_FILL: begin
                if (w_accept && (w_lane == 2'd3)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_word_last) begin
                    w_addr_clr  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_inc  = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Reader has picked up the batch once it leaves NODATA.
                if (!bus.OutOfData) begin
                    w_state_nxt = ST_IDLEWAIT;
                end
            end
            ST_IDLEWAIT: begin
                // Memory is ours again once the reader reports empty.
                if (bus.OutOfData) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase

        bus.rx_ready     = w_ready;
        bus.memWeB       = (r_state == ST_WRITE);
        bus.DONE_WRITING = (r_state == ST_DONE);
        bus.memAddrB     = 32'({w_word_addr, 2'b00});
        bus.memDataB     = r_word;
        bus.busy         = r_busy;
    end

    // FSM state, little-endian word assembly and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_word  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_busy <= 1'b1;
                if (w_sof_accept) begin
                    // Stale upper lanes from an abandoned word are cleared.
                    r_word <= {24'h000000, bus.rx_data};
                end else begin
                    r_word[{w_byte_cnt, 3'b000} +: 8] <= bus.rx_data;
                end
            end
            if ((r_state == ST_IDLEWAIT) && bus.OutOfData) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_host_word_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_host_word_loader
//  Description : Self-checking bench for host_word_loader. A cycle-level
//                reference model tracks bytes, words, writes and batch
//                hand-off and is compared to the DUT every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_host_word_loader;

    localparam int TOTAL   = 6;
    localparam int MAXWAIT = 200;
    localparam int NEVER   = 1 << 30;

    logic clock = 1'b0;
    logic reset;
    logic [7:0] drv_data;
    logic drv_valid, drv_sof, drv_ood;

    host_word_loader_if bus ();

    assign bus.rx_data   = drv_data;
    assign bus.rx_valid  = drv_valid;
    assign bus.rx_sof    = drv_sof;
    assign bus.OutOfData = drv_ood;

    host_word_loader #(
        .WORDS_PER_RECORD (6),
        .NUM_RECORDS      (1),
        .AW               (30)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          at;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    int         exp_done[$];
    logic [7:0] m_bytes[$];
    int         m_word_idx   = 0;
    int         m_fill_at    = 0;
    int         m_drain      = 0;   // 0: none, 1: waiting reader take, 2: waiting reader empty
    int         m_drain_from = 0;
    int         m_idle_from  = 0;
    bit         m_busy       = 0;
    bit         random_ood   = 0;

    task automatic model_reset();
        exp_wr.delete();
        exp_done.delete();
        m_bytes.delete();
        m_word_idx = 0;
        m_fill_at  = 0;
        m_drain    = 0;
        m_busy     = 0;
    endtask

    task automatic model_accept(input logic [7:0] b, input bit sof, input int k);
        logic [31:0] w;
        if (sof) begin
            m_bytes.delete();
            m_word_idx = 0;
        end
        m_bytes.push_back(b);
        m_busy = 1;
        if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            exp_wr.push_back('{at: k + 1, addr: 32'(m_word_idx * 4), data: w});
            m_bytes.delete();
            if (m_word_idx == TOTAL - 1) begin
                exp_done.push_back(k + 2);
                m_word_idx   = 0;
                m_drain      = 1;
                m_drain_from = k + 3;
                m_fill_at    = NEVER;
            end else begin
                m_word_idx++;
                m_fill_at = k + 2;
            end
        end
    endtask

    // One clock cycle: check outputs, drive inputs, check ready, advance model.
    task automatic step(input bit valid, input logic [7:0] data, input bit sof,
                        input bit ood, output bit accepted);
        int k;
        bit exp_we, exp_dn, exp_ready;
        @(negedge clock);
        k = cyc;
        exp_we = (exp_wr.size() > 0) && (exp_wr[0].at == k);
        chk("memWeB", bus.memWeB, exp_we);
        if (exp_we) begin
            chk("memAddrB", bus.memAddrB, exp_wr[0].addr);
            chk("memDataB", bus.memDataB, exp_wr[0].data);
        end
        while (exp_wr.size() > 0 && exp_wr[0].at <= k) void'(exp_wr.pop_front());
        exp_dn = (exp_done.size() > 0) && (exp_done[0] == k);
        chk("DONE_WRITING", bus.DONE_WRITING, exp_dn);
        while (exp_done.size() > 0 && exp_done[0] <= k) void'(exp_done.pop_front());
        chk("busy", bus.busy, m_busy);

        drv_ood   = ood;
        drv_valid = valid;
        drv_data  = data;
        drv_sof   = sof;
        #1;
        exp_ready = ood && (k >= m_fill_at) && (m_drain == 0);
        chk("rx_ready", bus.rx_ready, exp_ready);
        accepted = valid && exp_ready;

        if (m_drain == 1 && k >= m_drain_from && !ood) begin
            m_drain     = 2;
            m_idle_from = k + 1;
        end else if (m_drain == 2 && k >= m_idle_from && ood) begin
            m_drain   = 0;
            m_fill_at = k + 1;
            m_busy    = 0;
        end
        if (accepted) model_accept(data, sof, k);
    endtask

    task automatic idle(input int n, input bit ood);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), ood, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit sof, input int max_gap);
        bit acc;
        bit ood;
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        idle(gap, 1'b1);
        for (int i = 0; i < MAXWAIT; i++) begin
            ood = random_ood ? ($urandom_range(0, 7) != 0) : 1'b1;
            step(1'b1, b, sof, ood, acc);
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, MAXWAIT);
    endtask

    // Reader takes the batch: hold OutOfData high briefly, low 8 cycles, then high.
    task automatic drain_seq();
        idle(2, 1'b1);
        idle(8, 1'b0);
        idle(3, 1'b1);
    endtask

    task automatic reset_mid();
        #2;
        drv_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_memWeB", bus.memWeB, 1'b0);
        chk("rst_DONE", bus.DONE_WRITING, 1'b0);
        chk("rst_memAddrB", bus.memAddrB, 32'h0);
        chk("rst_memDataB", bus.memDataB, 32'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rx_ready", bus.rx_ready, drv_ood);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int batches;
        int guard;
        drv_data  = 8'h00;
        drv_valid = 1'b0;
        drv_sof   = 1'b0;
        drv_ood   = 1'b1;
        reset     = 1'b1;
        #2;
        chk("init_memWeB", bus.memWeB, 1'b0);
        chk("init_DONE", bus.DONE_WRITING, 1'b0);
        chk("init_memAddrB", bus.memAddrB, 32'h0);
        chk("init_memDataB", bus.memDataB, 32'h0);
        chk("init_busy", bus.busy, 1'b0);
        chk("init_rx_ready", bus.rx_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        // 01 02 03 04 back to back, then the rest of the batch.
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'h04, 1'b0, 0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0, 0);
        drain_seq();

        // Counting pattern 0x00..0x17 with random gaps.
        for (int i = 0; i < 24; i++) send_byte(8'(i), (i == 0), 2);
        drain_seq();

        // Partial progress abandoned by a new start of batch.
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), (i == 0), 1);
        send_byte(8'h5E, 1'b1, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b0, 0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0, 1);
        drain_seq();

        // Reader busy during fill: valid bytes must be refused.
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b0, 0);
        begin
            bit acc;
            for (int i = 0; i < 3; i++) step(1'b1, 8'h99, 1'b1, 1'b0, acc);
        end
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b0, 0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0, 0);
        drain_seq();

        // Reset after three words, then a fresh batch.
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), (i == 0), 0);
        idle(2, 1'b1);
        reset_mid();
        for (int i = 0; i < 24; i++) send_byte(8'($urandom), (i == 0), 1);
        drain_seq();

        // Random traffic: OutOfData glitches, stray starts of batch, gaps.
        random_ood = 1;
        batches    = 0;
        guard      = 0;
        while (batches < 4 && guard < 2000) begin
            guard++;
            if (m_drain != 0) begin
                drain_seq();
                batches++;
            end else begin
                send_byte(8'($urandom), ($urandom_range(0, 29) == 0), 2);
            end
        end
        random_ood = 0;
        chk("random_batches", 32'(batches), 32'd4);

        idle(4, 1'b1);
        chk("pending_writes", 32'(exp_wr.size()), 32'd0);
        chk("pending_done", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
